// File: rtl/pc.sv
// Program counter for the 8-bit CPU datapath: each clock it either steps by STEP
// or loads an absolute target from immediate; synchronous active-high reset.
module pc #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] STEP      = WIDTH'(1)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             PCsrc,
  input  logic [WIDTH-1:0] immediate,
  output logic [WIDTH-1:0] PC
);

  // immediate is only read on the load branch, so X there cannot reach PC while stepping
  always_ff @(posedge CLK) begin
    if (reset) begin
      PC <= RESET_VAL;
    end else if (PCsrc) begin
      PC <= immediate;
    end else begin
      PC <= PC + STEP;
    end
  end

endmodule

// File: tb/tb_pc.sv
// Directed bench for pc: reset, stepping, absolute loads, wrap, reset priority
// and immunity of PC to an unknown immediate while stepping.
module tb_pc;

  logic       CLK;
  logic       reset;
  logic       PCsrc;
  logic [7:0] immediate;
  logic [7:0] PC;

  int n_checks;
  int n_fail;

  pc #(.WIDTH(8), .RESET_VAL(8'h00), .STEP(8'h01)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .PCsrc     (PCsrc),
    .immediate (immediate),
    .PC        (PC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Apply inputs away from the edge, clock once, then compare #1 after the edge.
  task automatic step(input logic r, input logic src, input logic [7:0] imm,
                      input logic [7:0] exp_pc, input string tag);
    reset     = r;
    PCsrc     = src;
    immediate = imm;
    @(posedge CLK);
    #1;
    n_checks++;
    assert (PC === exp_pc) else begin
      n_fail++;
      $error("FAIL %s: PC=%02h expected %02h", tag, PC, exp_pc);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    PCsrc     = 1'b0;
    immediate = 8'h00;
    #2;

    step(1'b1, 1'b0, 8'h00, 8'h00, "reset_first");
    step(1'b1, 1'b0, 8'h00, 8'h00, "reset_hold1");
    step(1'b1, 1'b0, 8'h00, 8'h00, "reset_hold2");
    step(1'b1, 1'b0, 8'h00, 8'h00, "reset_hold3");

    step(1'b0, 1'b0, 8'h00, 8'h01, "inc_1");
    step(1'b0, 1'b0, 8'h00, 8'h02, "inc_2");

    step(1'b0, 1'b1, 8'h10, 8'h10, "load_10");
    step(1'b0, 1'b0, 8'h10, 8'h11, "resume_11");
    step(1'b0, 1'b1, 8'h20, 8'h20, "load_20");
    step(1'b0, 1'b0, 8'h20, 8'h21, "resume_21");
    step(1'b0, 1'b1, 8'h30, 8'h30, "load_30");
    step(1'b0, 1'b0, 8'h30, 8'h31, "resume_31");

    step(1'b0, 1'b1, 8'hFE, 8'hFE, "load_fe");
    step(1'b0, 1'b0, 8'h00, 8'hFF, "wrap_ff");
    step(1'b0, 1'b0, 8'h00, 8'h00, "wrap_00");
    step(1'b0, 1'b0, 8'h00, 8'h01, "wrap_01");

    step(1'b1, 1'b1, 8'h55, 8'h00, "reset_over_load");
    step(1'b0, 1'b0, 8'h55, 8'h01, "after_reset_01");

    step(1'b0, 1'b1, 8'h40, 8'h40, "load_40");
    step(1'b0, 1'b1, 8'h40, 8'h40, "self_load_40");
    step(1'b0, 1'b0, 8'hxx, 8'h41, "imm_x_inc_41");

    n_checks++;
    assert (!$isunknown(PC)) else begin
      n_fail++;
      $error("FAIL pc_no_x: PC=%02h expected no X bits", PC);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000;
    $display("FAIL timeout: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
